// File: rtl/reg_scoreboard_if.sv
// Issue / completion / register-file-write bundle for reg_scoreboard.
//   master : decode + execute side; drives issue and completion, observes
//            the scoreboard status and the register-file write port.
//   slave  : the scoreboard itself.
// Signals:
//   iss_valid/iss_ready      issue handshake
//   iss_wr, iss_rd           destination write flag and index
//   iss_rn/iss_rm            source indices, qualified by iss_use_rn/iss_use_rm
//   cmp_valid/cmp_rd/cmp_data completion, always accepted
//   wr_en/write_addr/write_data register-file write port (one cycle after cmp)
//   busy                     per-register pending-write flags
//   err                      sticky completion-without-pending flag
interface reg_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              iss_valid;
  logic              iss_ready;
  logic              iss_wr;
  logic [3:0]        iss_rd;
  logic [3:0]        iss_rn;
  logic [3:0]        iss_rm;
  logic              iss_use_rn;
  logic              iss_use_rm;
  logic              cmp_valid;
  logic [3:0]        cmp_rd;
  logic [DATA_W-1:0] cmp_data;
  logic              wr_en;
  logic [3:0]        write_addr;
  logic [DATA_W-1:0] write_data;
  logic [15:0]       busy;
  logic              err;

  modport master (
    output iss_valid, iss_wr, iss_rd, iss_rn, iss_rm, iss_use_rn, iss_use_rm,
    output cmp_valid, cmp_rd, cmp_data,
    input  iss_ready, wr_en, write_addr, write_data, busy, err
  );

  modport slave (
    input  iss_valid, iss_wr, iss_rd, iss_rn, iss_rm, iss_use_rn, iss_use_rm,
    input  cmp_valid, cmp_rd, cmp_data,
    output iss_ready, wr_en, write_addr, write_data, busy, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a 16-entry register file.
// Tracks outstanding writes per register with a small counter, stalls issue
// on read-after-write hazards or counter saturation, and stages completions
// into a one-cycle register-file write port.
// Ports:
//   clk    single clock, all state on rising edge
//   reset  asynchronous, active-high
//   sb     reg_scoreboard_if.slave (issue, completion, write port, busy, err)
module reg_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              reset,
  reg_scoreboard_if.slave   sb
);
  localparam int CNT_W = (MAX_PEND < 1) ? 1 : $clog2(MAX_PEND + 1);

  logic [CNT_W-1:0]  pend_q [16];
  logic [CNT_W-1:0]  pend_d [16];
  logic              wr_en_q, wr_en_d;
  logic [3:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [15:0]       busy;
  logic              iss_ready;
  logic              iss_fire;
  logic [15:0]       inc_vec;
  logic [15:0]       dec_vec;

  always_comb begin
    busy = '0;
    for (int i = 0; i < 16; i++) begin
      busy[i] = (pend_q[i] != '0);
    end
  end

  // Judged purely on current (pre-increment) state, so rd == rn sees the old busy.
  assign iss_ready = !((sb.iss_use_rn && busy[sb.iss_rn]) ||
                       (sb.iss_use_rm && busy[sb.iss_rm]) ||
                       (sb.iss_wr && (pend_q[sb.iss_rd] == CNT_W'(MAX_PEND))));

  assign iss_fire = sb.iss_valid && iss_ready;
  assign inc_vec  = (iss_fire && sb.iss_wr) ? (16'(1) << sb.iss_rd) : 16'h0000;
  // The decrement lands on the edge that retires the staged write, so busy
  // drops exactly when the register file holds the new value.
  assign dec_vec  = wr_en_q ? (16'(1) << addr_q) : 16'h0000;

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 16; i++) begin
      pend_d[i] = pend_q[i];
      if (dec_vec[i] && (pend_q[i] == '0)) begin
        err_d = 1'b1;
      end
      if (inc_vec[i] && !dec_vec[i]) begin
        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    wr_en_d = sb.cmp_valid;
    addr_d  = addr_q;
    data_d  = data_q;
    if (sb.cmp_valid) begin
      addr_d = sb.cmp_rd;
      data_d = sb.cmp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        pend_q[i] <= '0;
      end
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        pend_q[i] <= pend_d[i];
      end
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign sb.iss_ready  = iss_ready;
  assign sb.busy       = busy;
  assign sb.wr_en      = wr_en_q;
  assign sb.write_addr = addr_q;
  assign sb.write_data = data_q;
  assign sb.err        = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.DATA_W(32)) sb_if ();

  reg_scoreboard #(.DATA_W(32), .MAX_PEND(MAXP)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  typedef struct {
    logic        iv, wr;
    logic [3:0]  rd, rn, rm;
    logic        urn, urm;
    logic        cv;
    logic [3:0]  crd;
    logic [31:0] cd;
    logic        e_ready;
    logic [15:0] e_busy;
    logic        e_wr;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t tbl [27];

  // reference model state
  int          pend_m [16];
  logic        out_v;
  logic [3:0]  out_addr;
  logic [31:0] out_data;
  logic        err_m;
  int          outq [$];

  function automatic vec_t mk(input int iv, input int wr, input int rd, input int rn,
                              input int rm, input int urn, input int urm, input int cv,
                              input int crd, input logic [31:0] cd, input int er,
                              input logic [15:0] eb, input int ew, input int ea,
                              input logic [31:0] ed, input int ee);
    vec_t v;
    v.iv = 1'(iv); v.wr = 1'(wr); v.rd = 4'(rd); v.rn = 4'(rn); v.rm = 4'(rm);
    v.urn = 1'(urn); v.urm = 1'(urm); v.cv = 1'(cv); v.crd = 4'(crd); v.cd = cd;
    v.e_ready = 1'(er); v.e_busy = eb; v.e_wr = 1'(ew); v.e_addr = 4'(ea);
    v.e_data = ed; v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic wr, input logic [3:0] rd,
                       input logic [3:0] rn, input logic [3:0] rm, input logic urn,
                       input logic urm, input logic cv, input logic [3:0] crd,
                       input logic [31:0] cd);
    sb_if.iss_valid = iv;  sb_if.iss_wr = wr;   sb_if.iss_rd = rd;
    sb_if.iss_rn = rn;     sb_if.iss_rm = rm;
    sb_if.iss_use_rn = urn; sb_if.iss_use_rm = urm;
    sb_if.cmp_valid = cv;  sb_if.cmp_rd = crd;  sb_if.cmp_data = cd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend_m[i] = 0;
    out_v = 1'b0; out_addr = '0; out_data = '0; err_m = 1'b0;
    outq.delete();
  endtask

  function automatic logic model_ready();
    logic stall;
    stall = (sb_if.iss_use_rn && pend_m[sb_if.iss_rn] != 0) ||
            (sb_if.iss_use_rm && pend_m[sb_if.iss_rm] != 0) ||
            (sb_if.iss_wr && pend_m[sb_if.iss_rd] == MAXP);
    return !stall;
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i] = (pend_m[i] != 0);
    return b;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step(input logic rdy);
    if (out_v && pend_m[out_addr] == 0) err_m = 1'b1;
    if (sb_if.iss_valid && rdy && sb_if.iss_wr) begin
      pend_m[sb_if.iss_rd]++;
      outq.push_back(int'(sb_if.iss_rd));
    end
    if (out_v && pend_m[out_addr] > 0) pend_m[out_addr]--;
    out_v = sb_if.cmp_valid;
    if (sb_if.cmp_valid) begin
      out_addr = sb_if.cmp_rd;
      out_data = sb_if.cmp_data;
    end
  endtask

  initial begin
    tbl[0]  = mk(1,1,2,0,0,0,0, 0,0,32'h0,        1,16'h0000,0,0,32'h0,0);
    tbl[1]  = mk(1,0,0,2,0,1,0, 0,0,32'h0,        0,16'h0004,0,0,32'h0,0);
    tbl[2]  = mk(0,0,0,2,0,1,0, 1,2,32'hAAAAAAAA, 0,16'h0004,0,0,32'h0,0);
    tbl[3]  = mk(0,0,0,2,0,1,0, 0,0,32'h0,        0,16'h0004,1,2,32'hAAAAAAAA,0);
    tbl[4]  = mk(1,0,0,2,0,1,0, 0,0,32'h0,        1,16'h0000,0,2,32'hAAAAAAAA,0);
    tbl[5]  = mk(1,1,5,0,0,0,0, 0,0,32'h0,        1,16'h0000,0,2,32'hAAAAAAAA,0);
    tbl[6]  = mk(1,1,5,0,0,0,0, 0,0,32'h0,        1,16'h0020,0,2,32'hAAAAAAAA,0);
    tbl[7]  = mk(1,1,5,0,0,0,0, 0,0,32'h0,        1,16'h0020,0,2,32'hAAAAAAAA,0);
    tbl[8]  = mk(1,1,5,0,0,0,0, 0,0,32'h0,        0,16'h0020,0,2,32'hAAAAAAAA,0);
    tbl[9]  = mk(1,1,5,0,0,0,0, 1,5,32'h55550005, 0,16'h0020,0,2,32'hAAAAAAAA,0);
    tbl[10] = mk(1,1,5,0,0,0,0, 0,0,32'h0,        0,16'h0020,1,5,32'h55550005,0);
    tbl[11] = mk(1,1,5,0,0,0,0, 0,0,32'h0,        1,16'h0020,0,5,32'h55550005,0);
    tbl[12] = mk(0,0,0,0,0,0,0, 0,0,32'h0,        1,16'h0020,0,5,32'h55550005,0);
    tbl[13] = mk(1,1,7,0,0,0,0, 0,0,32'h0,        1,16'h0020,0,5,32'h55550005,0);
    tbl[14] = mk(0,0,0,0,0,0,0, 1,7,32'h00000007, 1,16'h00A0,0,5,32'h55550005,0);
    tbl[15] = mk(1,1,7,0,0,0,0, 0,0,32'h0,        1,16'h00A0,1,7,32'h00000007,0);
    tbl[16] = mk(0,0,0,0,0,0,0, 0,0,32'h0,        1,16'h00A0,0,7,32'h00000007,0);
    tbl[17] = mk(0,0,0,0,0,0,0, 1,9,32'h00000009, 1,16'h00A0,0,7,32'h00000007,0);
    tbl[18] = mk(0,0,0,0,0,0,0, 0,0,32'h0,        1,16'h00A0,1,9,32'h00000009,0);
    tbl[19] = mk(0,0,0,0,0,0,0, 0,0,32'h0,        1,16'h00A0,0,9,32'h00000009,1);
    tbl[20] = mk(0,0,0,0,0,0,0, 1,1,32'h00000011, 1,16'h00A0,0,9,32'h00000009,1);
    tbl[21] = mk(0,0,0,0,0,0,0, 1,3,32'h00000033, 1,16'h00A0,1,1,32'h00000011,1);
    tbl[22] = mk(0,0,0,0,0,0,0, 1,4,32'h00000044, 1,16'h00A0,1,3,32'h00000033,1);
    tbl[23] = mk(0,0,0,0,0,0,0, 0,0,32'h0,        1,16'h00A0,1,4,32'h00000044,1);
    tbl[24] = mk(1,0,0,5,7,0,0, 0,0,32'h0,        1,16'h00A0,0,4,32'h00000044,1);
    tbl[25] = mk(1,1,0,0,0,1,0, 0,0,32'h0,        1,16'h00A0,0,4,32'h00000044,1);
    tbl[26] = mk(0,0,0,0,0,0,0, 0,0,32'h0,        1,16'h00A1,0,4,32'h00000044,1);

    // reset state, checked before any clock edge
    drive(1,1,3,3,3,1,1, 1,6,32'h12345678);
    #2;
    check("rst_busy",  32'(sb_if.busy), 32'h0);
    check("rst_wr_en", 32'(sb_if.wr_en), 32'h0);
    check("rst_addr",  32'(sb_if.write_addr), 32'h0);
    check("rst_data",  sb_if.write_data, 32'h0);
    check("rst_err",   32'(sb_if.err), 32'h0);
    drive(0,0,0,0,0,0,0, 0,0,32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // directed table
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].iv, tbl[i].wr, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].urn,
            tbl[i].urm, tbl[i].cv, tbl[i].crd, tbl[i].cd);
      #3;
      check($sformatf("tbl%0d_ready", i), 32'(sb_if.iss_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_busy", i),  32'(sb_if.busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_wr_en", i), 32'(sb_if.wr_en), 32'(tbl[i].e_wr));
      check($sformatf("tbl%0d_addr", i),  32'(sb_if.write_addr), 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d_data", i),  sb_if.write_data, tbl[i].e_data);
      check($sformatf("tbl%0d_err", i),   32'(sb_if.err), 32'(tbl[i].e_err));
      @(posedge clk); #1;
    end

    // asynchronous reset with a pending count and a staged write in flight
    drive(0,0,0,0,0,0,0, 0,0,32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drive(1,1,2,0,0,0,0, 1,3,32'hDEADBEEF);
    @(posedge clk); #1;
    drive(0,0,0,0,0,0,0, 0,0,32'h0);
    #1;
    check("ar_busy_pre",  32'(sb_if.busy), 32'h0004);
    check("ar_wr_en_pre", 32'(sb_if.wr_en), 32'h1);
    reset = 1'b1;
    #1;
    check("ar_busy",  32'(sb_if.busy), 32'h0);
    check("ar_wr_en", 32'(sb_if.wr_en), 32'h0);
    check("ar_addr",  32'(sb_if.write_addr), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(0,1)), 4'($urandom), 4'($urandom), 4'($urandom),
            1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
      #3;
      check($sformatf("post_rst%0d_wr_en", i), 32'(sb_if.wr_en), 32'h0);
      check($sformatf("post_rst%0d_ready", i), 32'(sb_if.iss_ready), 32'h1);
      drive(0,0,0,0,0,0,0, 0,0,32'h0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end

    // randomized run against the model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        cv;
      logic [3:0]  crd;
      logic        rdy;
      cv  = 1'b0;
      crd = 4'h0;
      if (outq.size() > 0 && $urandom_range(0,99) < 45) begin
        int idx;
        idx = $urandom_range(0, outq.size() - 1);
        crd = 4'(outq[idx]);
        outq.delete(idx);
        cv  = 1'b1;
      end else if (c > 2000 && $urandom_range(0,99) < 2) begin
        crd = 4'($urandom);
        cv  = 1'b1;
      end
      drive(1'($urandom_range(0,99) < 70), 1'($urandom_range(0,99) < 60),
            4'($urandom_range(0,5)), 4'($urandom), 4'($urandom),
            1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
            cv, crd, $urandom);
      #3;
      rdy = model_ready();
      check("rnd_ready", 32'(sb_if.iss_ready), 32'(rdy));
      check("rnd_busy",  32'(sb_if.busy), 32'(model_busy()));
      check("rnd_wr_en", 32'(sb_if.wr_en), 32'(out_v));
      check("rnd_addr",  32'(sb_if.write_addr), 32'(out_addr));
      check("rnd_data",  sb_if.write_data, out_data);
      check("rnd_err",   32'(sb_if.err), 32'(err_m));
      model_step(rdy);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, width of completion and write data.
REQ-002 Parameter MAX_PEND, default 3, maximum outstanding writes tracked per register.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 iss_valid  input  1  issue request from decode; one instruction presented.
REQ-006 iss_ready  output  1  issue accepted this cycle when iss_valid and iss_ready are both 1.
REQ-007 iss_wr  input  1  issued instruction writes iss_rd.
REQ-008 iss_rd, iss_rn, iss_rm  input  4 each  destination and source register indices.
REQ-009 iss_use_rn, iss_use_rm  input  1 each  source operand is actually read.
REQ-010 cmp_valid  input  1  result completion from execute/memory; always accepted.
REQ-011 cmp_rd  input  4  completing destination index.
REQ-012 cmp_data  input  DATA_W  completing result.
REQ-013 wr_en  output  1  register file write enable.
REQ-014 write_addr  output  4  register file write index.
REQ-015 write_data  output  DATA_W  register file write data.
REQ-016 busy  output  16  bit i = 1 while register i has pending writes.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 Each register i SHALL own a pending counter pend[i] of width ceil(log2(MAX_PEND+1)); busy[i] = (pend[i] != 0), combinational from counter.
REQ-019 iss_ready SHALL be combinational: 0 if (iss_use_rn and busy[iss_rn]) or (iss_use_rm and busy[iss_rm]) or (iss_wr and pend[iss_rd] == MAX_PEND); else 1.
REQ-020 iss_ready SHALL not depend on iss_valid.
REQ-021 An accepted issue with iss_wr=1 SHALL increment pend[iss_rd] at the next posedge.
REQ-022 cmp_valid=1 SHALL register {cmp_rd, cmp_data} into the output stage: wr_en=1, write_addr=cmp_rd, write_data=cmp_data on the cycle after cmp_valid (latency 1).
REQ-023 wr_en SHALL be 0 in any cycle not preceded by cmp_valid=1; write_addr/write_data hold last value when wr_en=0.
REQ-024 pend[write_addr] SHALL decrement at the same posedge the register file captures the write (the edge ending the wr_en=1 cycle), so busy clears exactly when new data is readable.
REQ-025 Increment and decrement of the same register on the same edge SHALL leave pend unchanged.
REQ-026 A decrement of a register whose pend is 0 SHALL leave pend at 0 and set err; the register-file write still occurs.
REQ-027 An issue with iss_rd == iss_rn and iss_wr=1 SHALL be judged on the pre-increment busy state.
REQ-028 Sources that are not used (iss_use_rX=0) SHALL never stall, regardless of index.
REQ-029 Back-to-back cmp_valid every cycle SHALL produce wr_en=1 every cycle with no loss.
REQ-030 err SHALL remain 1 until reset.

Reset
REQ-031 While reset=1, independent of clk: all pend = 0, busy = 16'h0000, wr_en = 0, write_addr = 0, write_data = 0, err = 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending counts and any staged write (no wr_en pulse after reset release).
REQ-033 After reset deasserts, iss_ready SHALL be 1 for any request.

Verification
REQ-034 Issue rd=2 wr=1; next cycle issue rn=2 use_rn=1 -> iss_ready=0, busy=16'h0004; cmp_valid rd=2 data=32'hAAAAAAAA -> next cycle wr_en=1 addr=2 data=32'hAAAAAAAA; following cycle busy=0, iss_ready=1.
REQ-035 Issue rd=5 three times -> pend[5]=3; fourth issue rd=5 -> iss_ready=0; one completion rd=5 -> iss_ready=1 after its write edge.
REQ-036 Same cycle: accepted issue rd=7 and wr_en=1 write_addr=7 with pend[7]=1 -> pend[7] stays 1, busy[7]=1.
REQ-037 cmp_valid rd=9 with pend[9]=0 -> wr_en=1 addr=9 next cycle, err=1 and stays 1; pend[9]=0.
REQ-038 cmp_valid on rd=1,3,4 in consecutive cycles -> wr_en=1 for three consecutive cycles, addr 1,3,4 in order.
REQ-039 Assert reset asynchronously with pend[2]=1 and a staged write -> busy=0, wr_en=0 immediately; no write after release.
